// File: rtl/fifo_skew_pkg.sv
// -----------------------------------------------------------------------------
// fifo_skew_pkg
// Shared types and helpers for the transpose-FIFO skew sequencer.
//   state_e       : sequencer states (IDLE, SKEW, DRAIN, DONE)
//   cnt_width()   : width of the cycle counter, enough for 2*DEPTH+DRAIN
// -----------------------------------------------------------------------------
package fifo_skew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKEW  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The counter must reach 2*DEPTH-2 in SKEW and DRAIN-1 in DRAIN; sizing it
  // for the whole tile length keeps every compare bound representable.
  function automatic int cnt_width(input int depth, input int drain);
    return $clog2(2 * depth + drain);
  endfunction

endpackage : fifo_skew_pkg

// File: rtl/fifo_skew_ctrl_skew_window.sv
// -----------------------------------------------------------------------------
// skew_window
// Combinational diagonal-skew mask. Row i is live while the skew counter t is
// inside [i, i+DEPTH-1], so row i starts i cycles after row 0 and every row is
// live for exactly DEPTH counter values. Also used by the array-side column
// controller.
// Ports:
//   t_i         [CNT_W-1:0] skew counter value
//   en_i                    window active (sequencer is in its skew phase)
//   stall_i                 back-pressure; blanks the whole mask
//   row_valid_o [DEPTH-1:0] per-row live-operand mask
// -----------------------------------------------------------------------------
module skew_window #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0] t_i,
  input  logic             en_i,
  input  logic             stall_i,
  output logic [DEPTH-1:0] row_valid_o
);

  always_comb begin
    row_valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [CNT_W-1:0] lo;
      logic [CNT_W-1:0] hi;
      lo = CNT_W'(i);
      hi = CNT_W'(i + DEPTH - 1);
      row_valid_o[i] = en_i && !stall_i && (t_i >= lo) && (t_i <= hi);
    end
  end

endmodule : skew_window

// File: rtl/fifo_skew_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_skew_ctrl
// Sequencer for a bank of DEPTH transpose FIFOs feeding a DEPTH-wide systolic
// array. A tile-load handshake pulses the bank-wide write enable, then per-FIFO
// shift enables are staggered so row i starts i cycles after row 0. busy is
// held through an array drain window, after which done pulses for one cycle.
//
// Parameters:
//   DEPTH (>=2) : number of FIFOs/rows and elements per FIFO
//   DRAIN (>=1) : idle cycles after the last shift for array pipeline drain
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ld_valid/ld_ready : tile-load handshake (ready only when idle)
//   wr_en             : broadcast FIFO write enable, same edge as handshake
//   stall             : downstream back-pressure, freezes SKEW/DRAIN
//   shift_en[DEPTH]   : per-FIFO shift enable
//   row_valid[DEPTH]  : per-row live-operand flag
//   busy, done        : tile in flight / one-cycle completion pulse
//   stall_cycles[32]  : only with FIFO_SKEW_PERF_EN defined; saturating count
//                       of stalled SKEW/DRAIN cycles for the current tile
// Build option: define FIFO_SKEW_PERF_EN to add the stall_cycles counter.
// FIFO contents live outside this block and are not cleared by rst.
// -----------------------------------------------------------------------------
module fifo_skew_ctrl
  import fifo_skew_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DRAIN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             wr_en,
  input  logic             stall,
  output logic [DEPTH-1:0] shift_en,
  output logic [DEPTH-1:0] row_valid,
  output logic             busy,
  output logic             done
`ifdef FIFO_SKEW_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int CNT_W = cnt_width(DEPTH, DRAIN);

  localparam logic [CNT_W-1:0] SKEW_LAST  = CNT_W'(2 * DEPTH - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             handshake;

  assign handshake = ld_valid && (state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Stall only freezes progress in SKEW and DRAIN; DONE
  // always returns to IDLE so the completion pulse is exactly one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_SKEW;
          cnt_d   = '0;
        end
      end
      ST_SKEW: begin
        if (!stall) begin
          if (cnt_q == SKEW_LAST) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ld_ready = (state_q == ST_IDLE);
  assign wr_en    = handshake;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  skew_window #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_skew_window (
    .t_i         (cnt_q),
    .en_i        (state_q == ST_SKEW),
    .stall_i     (stall),
    .row_valid_o (row_valid)
  );

  // A FIFO shifts exactly when its row presents a live operand.
  assign shift_en = row_valid;

`ifdef FIFO_SKEW_PERF_EN
  // ---------------------------------------------------------------------------
  // Stall-cycle counter: restarts with each tile, holds after done so software
  // can read it between tiles, and saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;
  logic        stall_seen;

  assign stall_seen = stall && ((state_q == ST_SKEW) || (state_q == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (rst || handshake) begin
      stall_cnt_q <= '0;
    end else if (stall_seen && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule : fifo_skew_ctrl

// File: tb/tb_fifo_skew_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_skew_ctrl
// Directed bench for fifo_skew_ctrl with DEPTH=8, DRAIN=8. Inputs change 1 ns
// after a rising edge and outputs are compared 1 ns later, well before the next
// edge. Cycle numbers are relative to each tile's handshake cycle (cycle 0).
// With FIFO_SKEW_PERF_EN defined the stall_cycles output is also checked.
// -----------------------------------------------------------------------------
module tb_fifo_skew_ctrl;

  localparam int DEPTH   = 8;
  localparam int DRAIN   = 8;
  localparam int DONE_K  = 2 * DEPTH - 1 + DRAIN;  // progress steps before DONE
  localparam int NO_STALL_LO = 1000;
  localparam int NO_STALL_HI = -1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_valid;
  logic             stall;
  logic             ld_ready;
  logic             wr_en;
  logic [DEPTH-1:0] shift_en;
  logic [DEPTH-1:0] row_valid;
  logic             busy;
  logic             done;
`ifdef FIFO_SKEW_PERF_EN
  logic [31:0]      stall_cycles;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sh_log [0:63];
  int          done_at;
  logic [31:0] perf_prev;

  always #5 clk = ~clk;

  fifo_skew_ctrl #(
    .DEPTH (DEPTH),
    .DRAIN (DRAIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .wr_en        (wr_en),
    .stall        (stall),
    .shift_en     (shift_en),
    .row_valid    (row_valid),
    .busy         (busy),
    .done         (done)
`ifdef FIFO_SKEW_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Rows live for skew counter t: row i while i <= t <= i+DEPTH-1.
  function automatic logic [7:0] diag(input int t);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (t >= i) && (t <= i + DEPTH - 1);
    end
    return m;
  endfunction

  // One tile from its handshake cycle. Stall is high on cycles s0..s1.
  // rst_at >= 0 asserts rst on that cycle and ends the tile there.
  // force_at >= 0 preloads the stall counter to 32'hFFFFFFFE on that cycle.
  task automatic run_tile(input string name, input int s0, input int s1,
                          input bit hold_lv, input int rst_at, input int force_at);
    int last;
    int bits [DEPTH];
    last = (rst_at >= 0) ? rst_at : 2 * DEPTH + DRAIN + ((s1 >= s0) ? (s1 - s0 + 1) : 0);
    done_at = -1;
    for (int i = 0; i < DEPTH; i++) bits[i] = 0;
    for (int i = 0; i < 64; i++) sh_log[i] = '0;

    for (int c = 0; c <= last; c++) begin
      logic [7:0]  e_sh;
      logic        e_done;
      logic [63:0] e_perf;
      int          nst;
      int          k;
      bit          st;
      st       = (c >= s0) && (c <= s1);
      ld_valid = (c == 0) || hold_lv;
      stall    = st;
      rst      = (c == rst_at);
`ifdef FIFO_SKEW_PERF_EN
      if (c == force_at) begin
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        release dut.stall_cnt_q;
      end
`endif
      #1;
      nst = 0;
      for (int j = 1; j < c; j++) if ((j >= s0) && (j <= s1)) nst++;
      k = c - 1 - nst;

      if (c == 0) begin
        check($sformatf("%s.c%0d.ready", name, c), 32'(ld_ready), 32'd1);
        check($sformatf("%s.c%0d.wr", name, c),    32'(wr_en),    32'd1);
        check($sformatf("%s.c%0d.busy", name, c),  32'(busy),     32'd0);
        e_sh   = '0;
        e_done = 1'b0;
        e_perf = {32'd0, perf_prev};
      end else begin
        check($sformatf("%s.c%0d.ready", name, c), 32'(ld_ready), 32'd0);
        check($sformatf("%s.c%0d.wr", name, c),    32'(wr_en),    32'd0);
        check($sformatf("%s.c%0d.busy", name, c),  32'(busy),     32'd1);
        e_sh   = ((k <= 2 * DEPTH - 2) && !st) ? diag(k) : 8'h00;
        e_done = (k == DONE_K);
        if ((force_at >= 0) && (c >= force_at)) begin
          e_perf = 64'hFFFF_FFFE;
          for (int j = force_at; j < c; j++) if ((j >= s0) && (j <= s1)) e_perf++;
        end else begin
          e_perf = 64'(nst);
        end
        if (e_perf > 64'hFFFF_FFFF) e_perf = 64'hFFFF_FFFF;
      end
      check($sformatf("%s.c%0d.shift", name, c), 32'(shift_en),  32'(e_sh));
      check($sformatf("%s.c%0d.rowv", name, c),  32'(row_valid), 32'(e_sh));
      check($sformatf("%s.c%0d.done", name, c),  32'(done),      32'(e_done));
`ifdef FIFO_SKEW_PERF_EN
      check($sformatf("%s.c%0d.stallcyc", name, c), stall_cycles, e_perf[31:0]);
`endif
      if (c < 64) sh_log[c] = shift_en;
      for (int i = 0; i < DEPTH; i++) if (shift_en[i]) bits[i]++;
      if (done && (done_at < 0)) done_at = c;
      if (c == last) perf_prev = e_perf[31:0];
      @(posedge clk);
      #1;
    end

    if (rst_at < 0) begin
      for (int i = 0; i < DEPTH; i++)
        check($sformatf("%s.shifts_row%0d", name, i), 32'(bits[i]), 32'd8);
      check($sformatf("%s.done_cycle", name), 32'(done_at), 32'(last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    rst       = 1'b1;
    ld_valid  = 1'b0;
    stall     = 1'b0;
    perf_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    // Reset state
    check("reset.ready", 32'(ld_ready),  32'd1);
    check("reset.wr",    32'(wr_en),     32'd0);
    check("reset.busy",  32'(busy),      32'd0);
    check("reset.done",  32'(done),      32'd0);
    check("reset.shift", 32'(shift_en),  32'd0);
    check("reset.rowv",  32'(row_valid), 32'd0);
`ifdef FIFO_SKEW_PERF_EN
    check("reset.stallcyc", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Basic tile with ld_valid held high while busy (must be ignored).
    run_tile("basic", NO_STALL_LO, NO_STALL_HI, 1'b1, -1, -1);
    check("basic.sh_c1",  32'(sh_log[1]),  32'h01);
    check("basic.sh_c8",  32'(sh_log[8]),  32'hFF);
    check("basic.sh_c15", 32'(sh_log[15]), 32'h80);
    check("basic.sh_c16", 32'(sh_log[16]), 32'h00);
    check("basic.done_at", 32'(done_at),   32'd24);

    // Back-to-back: handshake on the cycle after done (cycle 25).
    run_tile("restart", NO_STALL_LO, NO_STALL_HI, 1'b0, -1, -1);
    check("restart.sh_c1", 32'(sh_log[1]), 32'h01);

    // Stall on cycles 6..8 freezes t=5.
    run_tile("stall", 6, 8, 1'b0, -1, -1);
    check("stall.sh_c6",  32'(sh_log[6]), 32'h00);
    check("stall.sh_c7",  32'(sh_log[7]), 32'h00);
    check("stall.sh_c8",  32'(sh_log[8]), 32'h00);
    check("stall.sh_c9",  32'(sh_log[9]), 32'h3F);
    check("stall.done_at", 32'(done_at),  32'd27);

    // Next tile: stall count holds 3 at handshake, clears right after.
    run_tile("clear", NO_STALL_LO, NO_STALL_HI, 1'b0, -1, -1);

    // Reset mid-tile at cycle 10.
    run_tile("rstmid", NO_STALL_LO, NO_STALL_HI, 1'b0, 10, -1);
    rst      = 1'b0;
    ld_valid = 1'b0;
    stall    = 1'b0;
    #1;
    check("rstmid.c11.ready", 32'(ld_ready), 32'd1);
    check("rstmid.c11.busy",  32'(busy),     32'd0);
    check("rstmid.c11.shift", 32'(shift_en), 32'd0);
    check("rstmid.c11.done",  32'(done),     32'd0);
    check("rstmid.c11.wr",    32'(wr_en),    32'd0);
`ifdef FIFO_SKEW_PERF_EN
    check("rstmid.c11.stallcyc", stall_cycles, 32'd0);
`endif
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) done_cnt++;
      @(posedge clk);
      #1;
    end
    check("rstmid.no_done", 32'(done_cnt), 32'd0);
    perf_prev = '0;

    // Stall on cycles 2..4; with the perf counter built in it is preloaded
    // to 32'hFFFFFFFE and must saturate at 32'hFFFFFFFF.
    run_tile("sat", 2, 4, 1'b0, -1, 2);
    check("sat.sh_c5", 32'(sh_log[5]), 32'h03);
    check("sat.done_at", 32'(done_at), 32'd27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_skew_ctrl
